tick_ctrl: RTL and testbench
============================

# tick_ctrl

- Run-control and tick-generation stage directly upstream of the seconds-digit down-counter chain.
- Divides the board clock into a one-cycle clock-enable pulse at `TICK_HZ` and drives the counters' `CE` input.
- Sequences start / pause / clear of the countdown and detects expiry from the chain's all-zero indication.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 1: tick rate. `DIV = CLK_HZ / TICK_HZ`, which must be an integer ≥ 2.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high; returns the block to IDLE.
- `start`  in  1: begin or resume counting.
- `pause`  in  1: freeze counting.
- `clear`  in  1: abort, return to IDLE, reload the downstream digits.
- `all_zero`  in  1: the downstream chain reads zero, for example the seconds digit `counter==0` AND'ed with the higher digits.
- `ce`  out  1: one-cycle tick, wired to the chain's `CE`.
- `digit_reset`  out  1: one-cycle pulse, wired to the chain's synchronous `reset`.
- `running`  out  1: high in RUN.
- `expired`  out  1: high in EXPIRED.

## Operation
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
- Command priority when several are active in the same cycle: `clear` > `start` > `pause`.
- IDLE:
  - `start`: if `all_zero`=0, go to RUN and zero the prescaler; if `all_zero`=1, go to EXPIRED.
  - `clear`: assert `digit_reset` and stay in IDLE.
- RUN:
  - `pause` → PAUSE.
  - `clear` → IDLE with `digit_reset`.
  - `all_zero`=1 with no tick pending → EXPIRED on the next edge.
  - `start` is ignored.
- PAUSE:
  - `start` → RUN. The prescaler resumes from its held value, preserving the tick phase.
  - `clear` → IDLE with `digit_reset`.
- EXPIRED:
  - `clear` → IDLE with `digit_reset`.
  - `start` and `pause` are ignored.
- Prescaler:
  - Width is `$clog2(DIV)`.
  - Increments only in RUN; wraps from DIV-1 to 0.
  - Held in PAUSE; forced to 0 in IDLE and EXPIRED.
- `ce` = (state==RUN) && (prescaler==DIV-1) && !`all_zero`. It is registered so it is glitch-free and one cycle wide.
- `ce` is never asserted outside RUN. It is never asserted while `all_zero`=1, so the chain cannot wrap from 0 to 9…

## Timing
- Reset values:
  - state = IDLE, prescaler = 0.
  - `ce`, `digit_reset`, `running`, `expired` = 0.
- Reset mid-operation takes effect immediately, with no clock required.
- First `ce` after `start` in IDLE comes exactly DIV cycles after the cycle in which `start` is sampled.
- Subsequent `ce` pulses are spaced exactly DIV cycles apart.
- `running` and `expired` reflect the state register, so they follow the sampling edge with no extra delay.
- `digit_reset` is high for exactly the one cycle after `clear` is sampled.
- Expiry latency: the `ce` that drives the chain to zero is followed by `all_zero` on the next cycle, and `expired` rises one cycle after that.
- A `pause` sampled in the same cycle as prescaler==DIV-1 suppresses that tick. The tick is delivered on the first RUN cycle after resume.

## Configuration
- Macro: `TICK_CTRL_EDGE_DETECT_EN`.
- Defined:
  - `start`, `pause` and `clear` are level inputs from already-debounced buttons.
  - Each goes through an internal rising-edge detector (previous-value register, reset to 0).
  - Only the 0→1 transition acts as a command, which adds one cycle of command latency.
- Undefined: inputs are treated as single-cycle command pulses and used directly. A held level re-issues the command every cycle.

## Structure
- Shared package `tick_pkg`:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3.
  - Default `CLK_HZ` and `TICK_HZ` constants, used by the top level and testbench.
- One sub-module, `tick_prescaler`, with:
  - parameter `DIV`;
  - inputs `clk`, `reset`, `run`, `zero`;
  - output `wrap`, high when count==DIV-1 and `run`.
- The FSM and the `ce` gating stay in `tick_ctrl`.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1, DIV=10.
- Reset released, no commands for 50 cycles → `ce`=0, `running`=0, `expired`=0, `digit_reset`=0 throughout.
- `start` at cycle 0 with `all_zero`=0 → `running`=1; `ce` pulses at cycles 10, 20, 30, each one cycle wide.
- `start`, then `pause` at cycle 15, then `start` at cycle 40 → no `ce` during 15–40; next `ce` at cycle 45.
- Running, `all_zero` driven to 1 one cycle after the `ce` at cycle 30 → no further `ce`; `expired`=1 by cycle 33; `clear` then gives `digit_reset` for one cycle and IDLE.
- `clear`, `start` and `pause` asserted in the same cycle from RUN → IDLE plus a `digit_reset` pulse; `running`=0.
- Async `reset` asserted mid-RUN between edges → all outputs 0 immediately; after release, `start` gives the first `ce` exactly 10 cycles later.

Source files
------------

// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared state encoding and default rates for tick_ctrl
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } tick_state_e;

  localparam int CLK_HZ_DEFAULT  = 100_000_000;
  localparam int TICK_HZ_DEFAULT = 1;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - modulo-DIV prescaler with hold, clear and wrap flag
module tick_prescaler
  import tick_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic zero,
  output logic wrap
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap = run && (count_q == LAST);

  // Next count: clear wins, otherwise advance only when enabled; no run means hold
  always_comb begin
    count_d = count_q;
    if (zero) begin
      count_d = '0;
    end else if (run) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - run control and CE tick generation; TICK_CTRL_EDGE_DETECT_EN enables button edge detection
module tick_ctrl
  import tick_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = TICK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause,
  input  logic clear,
  input  logic all_zero,
  output logic ce,
  output logic digit_reset,
  output logic running,
  output logic expired
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  tick_state_e state_q;
  logic        ce_q;
  logic        digit_reset_q;
  logic        start_cmd;
  logic        pause_cmd;
  logic        clear_cmd;
  logic        presc_run;
  logic        presc_zero;
  logic        wrap;

`ifdef TICK_CTRL_EDGE_DETECT_EN
  logic start_prev_q, pause_prev_q, clear_prev_q;
  logic start_cmd_q, pause_cmd_q, clear_cmd_q;

  // Turn debounced button levels into registered one-cycle rising-edge commands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
      start_cmd_q  <= 1'b0;
      pause_cmd_q  <= 1'b0;
      clear_cmd_q  <= 1'b0;
    end else begin
      start_prev_q <= start;
      pause_prev_q <= pause;
      clear_prev_q <= clear;
      start_cmd_q  <= start & ~start_prev_q;
      pause_cmd_q  <= pause & ~pause_prev_q;
      clear_cmd_q  <= clear & ~clear_prev_q;
    end
  end

  assign start_cmd = start_cmd_q;
  assign pause_cmd = pause_cmd_q;
  assign clear_cmd = clear_cmd_q;
`else
  assign start_cmd = start;
  assign pause_cmd = pause;
  assign clear_cmd = clear;
`endif

  // Prescaler advances in RUN unless leaving it; a resume counts as a run cycle so
  // that a tick suppressed by pause is delivered on the first RUN cycle after start.
  assign presc_run  = !clear_cmd &&
                      (((state_q == RUN) && !pause_cmd) ||
                       ((state_q == PAUSE) && start_cmd));
  assign presc_zero = (state_q == IDLE) || (state_q == EXPIRED) || clear_cmd;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (presc_run),
    .zero  (presc_zero),
    .wrap  (wrap)
  );

  // Run-control FSM with registered tick and digit-reload pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ce_q          <= 1'b0;
      digit_reset_q <= 1'b0;
    end else begin
      ce_q          <= wrap && !all_zero;
      digit_reset_q <= clear_cmd;
      case (state_q)
        IDLE: begin
          if (!clear_cmd && start_cmd) begin
            state_q <= all_zero ? EXPIRED : RUN;
          end
        end
        RUN: begin
          if (clear_cmd) begin
            state_q <= IDLE;
          end else if (pause_cmd) begin
            state_q <= PAUSE;
          end else if (all_zero && !ce_q) begin
            state_q <= EXPIRED;
          end
        end
        PAUSE: begin
          if (clear_cmd) begin
            state_q <= IDLE;
          end else if (start_cmd) begin
            state_q <= RUN;
          end
        end
        EXPIRED: begin
          if (clear_cmd) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ce          = ce_q;
  assign digit_reset = digit_reset_q;
  assign running     = (state_q == RUN);
  assign expired     = (state_q == EXPIRED);

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - scoreboard testbench for tick_ctrl with DIV=10
module tb_tick_ctrl;
  import tick_pkg::*;

  localparam int CLK_HZ = 10;

  logic clk;
  logic reset;
  logic start;
  logic pause;
  logic clear;
  logic all_zero;
  logic ce;
  logic digit_reset;
  logic running;
  logic expired;

  typedef struct {
    int         tag;
    int         scn;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ecount = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   base;

  tick_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ_DEFAULT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .all_zero    (all_zero),
    .ce          (ce),
    .digit_reset (digit_reset),
    .running     (running),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  // Monitor: each expected entry is tagged with the edge index after which it holds
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= ecount - 1) begin
      e = sb.pop_front();
      n_cmp = n_cmp + 1;
      if (e.tag != ecount - 1 || {ce, digit_reset, running, expired} !== e.v) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs scn=%0d cyc=%0d got ce/dr/run/exp=%b want=%b",
                 e.scn, e.tag - base, {ce, digit_reset, running, expired}, e.v);
      end
    end
  end

  task automatic push(input int scn, input int tag, input logic c, input logic d,
                      input logic r, input logic x);
    exp_t n;
    n.tag = tag;
    n.scn = scn;
    n.v   = {c, d, r, x};
    sb.push_back(n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; all_zero = 1'b0;
    base = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Scenario 1: idle after reset, no commands
    base = ecount;
    for (int k = 0; k < 50; k++) push(1, base + k, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (50) cyc();

    // Scenario 2: start, ticks at 10/20/30, all_zero after tick 30, expiry, clear
    base = ecount;
    for (int k = 0; k <= 50; k++)
      push(2, base + k, (k == 10 || k == 20 || k == 30), (k == 46), (k <= 31),
           (k >= 32 && k <= 45));
    for (int k = 0; k <= 50; k++) begin
      start = (k == 0);
      clear = (k == 46);
      cyc();
      if (k == 31) all_zero = 1'b1;
      if (k == 46) all_zero = 1'b0;
    end
    start = 1'b0; clear = 1'b0;

    // Scenario 3: start from IDLE while chain already reads zero
    all_zero = 1'b1;
    base = ecount;
    push(3, base + 0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3, base + 1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3, base + 2, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3, base + 3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      start = (k == 0);
      clear = (k == 2);
      cyc();
    end
    start = 1'b0; clear = 1'b0; all_zero = 1'b0;

    // Scenario 4: pause on the wrap cycle suppresses the tick, resume delivers it
    base = ecount;
    for (int k = 0; k <= 28; k++)
      push(4, base + k, (k == 15 || k == 25), (k == 27), (k <= 9 || (k >= 15 && k <= 26)),
           1'b0);
    for (int k = 0; k <= 28; k++) begin
      start = (k == 0 || k == 15);
      pause = (k == 10);
      clear = (k == 27);
      cyc();
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0;

    // Scenario 5: pause at 15, resume at 40, then clear+start+pause together
    base = ecount;
    for (int k = 0; k <= 55; k++)
      push(5, base + k, (k == 10 || k == 45), (k == 52), (k <= 14 || (k >= 40 && k <= 51)),
           1'b0);
    for (int k = 0; k <= 55; k++) begin
      start = (k == 0 || k == 40 || k == 52);
      pause = (k == 15 || k == 52);
      clear = (k == 52);
      cyc();
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0;

    // Scenario 6: async reset mid-cycle while ce is high, then restart
    base = ecount;
    for (int k = 0; k <= 12; k++) push(6, base + k, 1'b0, 1'b0, (k <= 9), 1'b0);
    for (int k = 0; k <= 9; k++) begin
      start = (k == 0);
      cyc();
    end
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    base = ecount;
    for (int k = 0; k <= 12; k++) push(7, base + k, (k == 10), (k == 12), (k <= 11), 1'b0);
    for (int k = 0; k <= 12; k++) begin
      start = (k == 0);
      clear = (k == 12);
      cyc();
    end
    start = 1'b0; clear = 1'b0;

    repeat (3) cyc();
    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
